// File: rtl/uop_rename.sv
// Two-wide register rename stage: speculative RAT, committed RAT and per-branch-tag checkpoints.
// Renamed uops are registered, so they reach dispatch one cycle after the pair is accepted.
module uop_rename #(
    parameter int NUM_AREGS         = 16,
    parameter int NUM_PREGS         = 64,
    parameter int MAX_PREDICT_DEPTH = 4,
    localparam int AW = $clog2(NUM_AREGS),
    localparam int PW = $clog2(NUM_PREGS),
    localparam int TW = $clog2(MAX_PREDICT_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                prev_valid,
    input  logic                next_stalled,
    output logic                stalled,
    output logic                valid,
    input  logic [1:0]          in_noop,
    input  logic [1:0]          in_has_dest,
    input  logic [1:0][AW-1:0]  in_rd,
    input  logic [1:0][AW-1:0]  in_rs1,
    input  logic [1:0][AW-1:0]  in_rs2,
    input  logic [1:0][PW-1:0]  in_preg,
    input  logic [1:0]          in_is_branch,
    input  logic [1:0][TW-1:0]  in_branch_tag,
    input  logic                branch_shootdown,
    input  logic [TW-1:0]       shootdown_tag,
    input  logic                commit_valid,
    input  logic [AW-1:0]       commit_areg,
    input  logic [PW-1:0]       commit_preg,
    output logic [1:0][PW-1:0]  out_prs1,
    output logic [1:0][PW-1:0]  out_prs2,
    output logic [1:0][PW-1:0]  out_prd,
    output logic [1:0][PW-1:0]  out_old_prd
);

    logic [PW-1:0] rat      [NUM_AREGS];
    logic [PW-1:0] crat     [NUM_AREGS];
    logic [PW-1:0] ckpt     [MAX_PREDICT_DEPTH][NUM_AREGS];
    logic [PW-1:0] rat_mid  [NUM_AREGS];
    logic [PW-1:0] rat_nxt  [NUM_AREGS];
    logic [PW-1:0] crat_nxt [NUM_AREGS];

    logic [1:0]         has_rd;
    logic [1:0]         take_ckpt;
    logic [1:0][PW-1:0] prs1, prs2, prd, old_prd;
    logic               accept;
    logic               same_rd;

    assign accept = prev_valid && !next_stalled;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            has_rd[s]    = in_has_dest[s] && !in_noop[s] && (in_rd[s] != '0);
            take_ckpt[s] = in_is_branch[s] && !in_noop[s];
        end
        same_rd = has_rd[0] && has_rd[1] && (in_rd[0] == in_rd[1]);

        rat_mid = rat;
        if (has_rd[0]) rat_mid[in_rd[0]] = in_preg[0];
        rat_nxt = rat_mid;
        if (has_rd[1]) rat_nxt[in_rd[1]] = in_preg[1];

        // A commit landing in the same cycle as a clear must already be visible in the restored RAT.
        crat_nxt = crat;
        if (commit_valid && commit_areg != '0) crat_nxt[commit_areg] = commit_preg;

        prs1[0]    = rat[in_rs1[0]];
        prs2[0]    = rat[in_rs2[0]];
        prs1[1]    = (has_rd[0] && in_rs1[1] == in_rd[0]) ? in_preg[0] : rat[in_rs1[1]];
        prs2[1]    = (has_rd[0] && in_rs2[1] == in_rd[0]) ? in_preg[0] : rat[in_rs2[1]];
        prd[0]     = has_rd[0] ? in_preg[0] : '0;
        prd[1]     = has_rd[1] ? in_preg[1] : '0;
        old_prd[0] = has_rd[0] ? rat[in_rd[0]] : '0;
        old_prd[1] = !has_rd[1] ? '0 : (same_rd ? in_preg[0] : rat[in_rd[1]]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < NUM_AREGS; a++) begin
                rat[a]  <= PW'(a);
                crat[a] <= PW'(a);
                for (int t = 0; t < MAX_PREDICT_DEPTH; t++) ckpt[t][a] <= PW'(a);
            end
            valid       <= 1'b0;
            stalled     <= 1'b0;
            out_prs1    <= '0;
            out_prs2    <= '0;
            out_prd     <= '0;
            out_old_prd <= '0;
        end else begin
            crat <= crat_nxt;
            if (clear) begin
                rat     <= crat_nxt;
                valid   <= 1'b0;
                stalled <= 1'b0;
            end else if (branch_shootdown) begin
                rat     <= ckpt[shootdown_tag];
                valid   <= 1'b0;
                stalled <= next_stalled;
            end else begin
                valid   <= accept;
                stalled <= next_stalled;
                if (accept) begin
                    rat         <= rat_nxt;
                    out_prs1    <= prs1;
                    out_prs2    <= prs2;
                    out_prd     <= prd;
                    out_old_prd <= old_prd;
                    // Slot 0's snapshot excludes slot 1's write; slot 1's includes both.
                    if (take_ckpt[0]) ckpt[in_branch_tag[0]] <= rat_mid;
                    if (take_ckpt[1]) ckpt[in_branch_tag[1]] <= rat_nxt;
                end
            end
        end
    end

endmodule

// File: doc/uop_rename.md
Name: uop_rename

Overview:
- Two-wide register rename stage, directly downstream of the decode/preg-allocation stage.
- Consumes a decoded instruction pair plus the two freshly allocated physical registers.
- Maps architectural sources and destinations through a speculative register alias table (RAT) and snapshots the RAT per branch tag.
- Restores the RAT on branch shootdown or full clear, and emits renamed uops to the dispatch stage one cycle later.

Parameters:
- NUM_AREGS, 16, number of architectural registers; areg 0 is hardwired zero.
- NUM_PREGS, 64, number of physical registers; preg 0 is permanently bound to areg 0.
- MAX_PREDICT_DEPTH, 4, number of in-flight branch tags (checkpoint slots).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- clear  in  1  full pipeline flush; restore RAT from the committed RAT
- prev_valid  in  1  upstream pair valid
- next_stalled  in  1  dispatch stage cannot accept
- stalled  out  1  this stage is stalled (registered)
- valid  out  1  renamed pair valid (registered)
- in_noop[2]  in  1 each  slot is a no-op
- in_has_dest[2]  in  1 each  slot writes rd
- in_rd[2], in_rs1[2], in_rs2[2]  in  clog2(NUM_AREGS) each  architectural regs
- in_preg[2]  in  clog2(NUM_PREGS) each  allocated destination preg
- in_is_branch[2]  in  1 each  slot is a branch
- in_branch_tag[2]  in  clog2(MAX_PREDICT_DEPTH) each  tag of the branch
- branch_shootdown  in  1  mispredict recovery request
- shootdown_tag  in  clog2(MAX_PREDICT_DEPTH)  checkpoint to restore
- commit_valid  in  1  one retirement this cycle
- commit_areg  in  clog2(NUM_AREGS)  retired destination areg
- commit_preg  in  clog2(NUM_PREGS)  retired destination preg
- out_prs1[2], out_prs2[2]  out  clog2(NUM_PREGS) each  renamed sources
- out_prd[2]  out  clog2(NUM_PREGS) each  renamed destination (0 if none)
- out_old_prd[2]  out  clog2(NUM_PREGS) each  previous mapping of rd, freed at commit

Behaviour:
- Effective destination: a slot has one iff in_has_dest=1, in_noop=0 and in_rd!=0. Otherwise out_prd=0, out_old_prd=0 and the RAT is untouched.
- Reset:
  - RAT and committed RAT become identity (areg a -> preg a).
  - All checkpoints become identity.
  - valid=0, stalled=0, all data outputs 0.
- Priority, highest first: reset > clear > branch_shootdown > normal.
  - clear: RAT <= committed RAT, including a same-cycle commit forwarded in; valid<=0; stalled<=0.
  - shootdown: RAT <= checkpoint[shootdown_tag]; valid<=0; the incoming pair is discarded, with no RAT update and no snapshot.
- Normal operation, on a cycle with next_stalled=0 and prev_valid=1:
  - Outputs are registered with latency 1, and valid<=1.
  - Slot 0 sources read the current RAT.
  - Slot 1 sources read the current RAT, except an rs equal to slot 0's effective rd, which takes in_preg[0] (intra-pair bypass).
  - out_old_prd[0] = RAT[rd0].
  - out_old_prd[1] = in_preg[0] if rd1==rd0 and both slots have a destination; otherwise RAT[rd1].
  - RAT update: slot 1 wins when both slots write the same areg.
- Normal operation, other cycles:
  - next_stalled=0 and prev_valid=0: valid<=0, RAT unchanged.
  - next_stalled=1: valid<=0, stalled<=1, RAT unchanged, outputs hold.
  - stalled<=0 on any cycle with next_stalled=0.
- Checkpoints, taken only on accepted, non-shot-down cycles:
  - Slot 0 branch: checkpoint[tag0] <= RAT after the slot 0 update only.
  - Slot 1 branch: checkpoint[tag1] <= RAT after both updates.
  - Both slots branches with distinct tags: both snapshots are written.
- Commit: when commit_valid=1, committed RAT[commit_areg] <= commit_preg every cycle, independent of stall. Commits with commit_areg=0 are ignored.
- Areg 0 always maps to preg 0 in every table.

Test Plan:
- Reset, then rename pair {rd=3,rs1=3,preg=20} and {rd=5,rs1=3,rs2=5,preg=21} -> next cycle valid=1; slot0 prs1=3, prd=20, old_prd=3; slot1 prs1=20 (bypass), prs2=5, prd=21, old_prd=5.
- Same-destination pair {rd=7,preg=30} and {rd=7,rs1=7,preg=31} -> slot1 prs1=30, old_prd=30; a subsequent read of areg 7 returns 31.
- Slot0 branch tag 2 followed by renames of areg 4 to 40 then 41; shootdown_tag=2 -> valid=0 that cycle, and a later read of areg 4 returns its pre-branch mapping (4).
- next_stalled held high for 3 cycles with prev_valid=1 -> valid=0, stalled=1, RAT unchanged; after release the pair renames exactly once.
- Commit areg 2 -> preg 50 with clear asserted in the same cycle -> following reads give areg 2 = 50 and all other aregs identity (speculative renames discarded).
- Destination rd=0 with has_dest=1 and preg=60 -> out_prd=0, out_old_prd=0, areg 0 still maps to preg 0.
